// File: rtl/core_biu_arbiter.sv
// core_biu_arbiter: IFU/LSU arbiter onto a single-outstanding memory request port
module core_biu_arbiter #(
  parameter int XLEN         = 32,
  parameter int WMASK_W      = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ifu_req_valid_i,
  output logic               ifu_req_ready_o,
  input  logic [XLEN-1:0]    ifu_req_addr_i,
  input  logic               ifu_flush_i,
  output logic               ifu_rsp_valid_o,
  output logic [XLEN-1:0]    ifu_rsp_data_o,
  input  logic               lsu_req_valid_i,
  output logic               lsu_req_ready_o,
  input  logic [XLEN-1:0]    lsu_req_addr_i,
  input  logic [XLEN-1:0]    lsu_req_wdata_i,
  input  logic [WMASK_W-1:0] lsu_req_wmask_i,
  input  logic               lsu_req_wen_i,
  output logic               lsu_rsp_valid_o,
  output logic [XLEN-1:0]    lsu_rsp_data_o,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic [XLEN-1:0]    mem_addr_o,
  output logic [XLEN-1:0]    mem_wdata_o,
  output logic [WMASK_W-1:0] mem_wmask_o,
  output logic               mem_wen_o,
  input  logic               mem_rsp_valid_i,
  input  logic [XLEN-1:0]    mem_rsp_data_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_e             state_q, state_d;
  logic [3:0]         starve_q, starve_d;
  logic               drop_q, drop_d;
  logic               owner_q, owner_d;
  logic [XLEN-1:0]    addr_q, addr_d, wdata_q, wdata_d;
  logic [WMASK_W-1:0] wmask_q, wmask_d;
  logic               wen_q, wen_d;
  logic               ifu_ok, lsu_win, ifu_win, rsp_fire;
  // owner_q is 1 for an IFU transaction; ready is gated by rst_n so it stays low during reset
  assign ifu_ok          = ifu_req_valid_i & ~ifu_flush_i;
  assign lsu_win         = rst_n & (state_q == IDLE) & lsu_req_valid_i & ~(ifu_ok & (starve_q == LIMIT));
  assign ifu_win         = rst_n & (state_q == IDLE) & ifu_ok & ~lsu_win;
  assign rsp_fire        = (state_q == WAIT) & mem_rsp_valid_i;
  assign ifu_req_ready_o = ifu_win;
  assign lsu_req_ready_o = lsu_win;
  assign mem_req_valid_o = state_q == REQ;
  assign mem_addr_o      = addr_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_wmask_o     = wmask_q;
  assign mem_wen_o       = wen_q;
  assign ifu_rsp_valid_o = rsp_fire & owner_q & ~drop_q & ~ifu_flush_i;
  assign lsu_rsp_valid_o = rsp_fire & ~owner_q;
  assign ifu_rsp_data_o  = ifu_rsp_valid_o ? mem_rsp_data_i : '0;
  assign lsu_rsp_data_o  = lsu_rsp_valid_o ? mem_rsp_data_i : '0;
  // next state: grant and latch in IDLE, hand off in REQ, retire in WAIT (latched fields cleared on retire)
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    drop_d   = drop_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    wen_d    = wen_q;
    if (lsu_win) begin
      state_d  = REQ;
      owner_d  = 1'b0;
      addr_d   = lsu_req_addr_i;
      wdata_d  = lsu_req_wdata_i;
      wmask_d  = lsu_req_wmask_i;
      wen_d    = lsu_req_wen_i;
      starve_d = (ifu_ok && starve_q < LIMIT) ? starve_q + 4'd1 : starve_q;
    end else if (ifu_win) begin
      state_d  = REQ;
      owner_d  = 1'b1;
      addr_d   = ifu_req_addr_i;
      wdata_d  = '0;
      wmask_d  = '0;
      wen_d    = 1'b0;
      starve_d = '0;
    end else if (state_q == REQ && mem_req_ready_i) begin
      state_d = WAIT;
    end else if (rsp_fire) begin
      state_d = IDLE;
      drop_d  = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      wmask_d = '0;
      wen_d   = 1'b0;
    end
    if (state_q != IDLE && state_d != IDLE && owner_q && ifu_flush_i) drop_d = 1'b1;
  end
  // state register with asynchronous reset that abandons any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      drop_q   <= 1'b0;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      wen_q    <= wen_d;
    end
  end
endmodule

// File: tb/tb_core_biu_arbiter.sv
// tb_core_biu_arbiter: scoreboard bench for core_biu_arbiter with a transaction-level reference model
module tb_core_biu_arbiter;
  localparam int LIM = 4;
  logic clk = 0, rst_n = 0;
  logic ifu_req_valid = 0, ifu_flush = 0, lsu_req_valid = 0, lsu_req_wen = 0;
  logic [31:0] ifu_req_addr = 0, lsu_req_addr = 0, lsu_req_wdata = 0, mem_rsp_data = 0;
  logic [3:0] lsu_req_wmask = 0;
  logic mem_req_ready = 0, mem_rsp_valid = 0;
  logic ifu_req_ready_o, ifu_rsp_valid_o, lsu_req_ready_o, lsu_rsp_valid_o, mem_req_valid_o, mem_wen_o;
  logic [31:0] ifu_rsp_data_o, lsu_rsp_data_o, mem_addr_o, mem_wdata_o;
  logic [3:0] mem_wmask_o;

  core_biu_arbiter #(.XLEN(32), .WMASK_W(4), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid_i(ifu_req_valid), .ifu_req_ready_o(ifu_req_ready_o), .ifu_req_addr_i(ifu_req_addr),
    .ifu_flush_i(ifu_flush), .ifu_rsp_valid_o(ifu_rsp_valid_o), .ifu_rsp_data_o(ifu_rsp_data_o),
    .lsu_req_valid_i(lsu_req_valid), .lsu_req_ready_o(lsu_req_ready_o), .lsu_req_addr_i(lsu_req_addr),
    .lsu_req_wdata_i(lsu_req_wdata), .lsu_req_wmask_i(lsu_req_wmask), .lsu_req_wen_i(lsu_req_wen),
    .lsu_rsp_valid_o(lsu_rsp_valid_o), .lsu_rsp_data_o(lsu_rsp_data_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_wen_o(mem_wen_o),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_data_i(mem_rsp_data)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  // stimulus knobs written only by the main sequence
  bit auto_drv = 0, spur = 0, fix_en = 0;
  int rdy_pct = 100, dly_min = 0, dly_max = 0, kick_req = 0;
  logic [31:0] fix_data = 0;
  logic d_ifu_v = 0, d_flush = 0, d_lsu_v = 0, d_lsu_wen = 0;
  logic [31:0] d_ifu_addr = 0, d_lsu_addr = 0, d_lsu_wdata = 0;
  logic [3:0] d_lsu_wmask = 0;

  // driver: requesters (random or directed) and a memory with random ready and response delay
  bit l_hs, i_hs, acc, pend;
  int cnt, kick_done = 0;
  always begin
    @(negedge clk);
    l_hs = lsu_req_valid && lsu_req_ready_o;
    i_hs = ifu_req_valid && ifu_req_ready_o;
    acc = mem_req_valid_o && mem_req_ready;
    if (!rst_n) pend = 0;
    @(posedge clk); #1;
    if (auto_drv) begin
      if (!lsu_req_valid || l_hs) begin
        lsu_req_valid = $urandom_range(0, 99) < 50;
        lsu_req_addr = $urandom;
        lsu_req_wdata = $urandom;
        lsu_req_wmask = 4'($urandom);
        lsu_req_wen = 1'($urandom);
      end
      if (!ifu_req_valid || i_hs) begin
        ifu_req_valid = $urandom_range(0, 99) < 60;
        ifu_req_addr = $urandom;
      end
      ifu_flush = $urandom_range(0, 11) == 0;
    end else begin
      lsu_req_valid = d_lsu_v; lsu_req_addr = d_lsu_addr; lsu_req_wdata = d_lsu_wdata;
      lsu_req_wmask = d_lsu_wmask; lsu_req_wen = d_lsu_wen;
      ifu_req_valid = d_ifu_v; ifu_req_addr = d_ifu_addr; ifu_flush = d_flush;
    end
    mem_rsp_valid = 0;
    if (!rst_n) begin
      pend = 0;
      mem_req_ready = 0;
    end else begin
      if (acc) begin pend = 1; cnt = $urandom_range(dly_max, dly_min); end
      if (pend) begin
        if (cnt == 0) begin
          mem_rsp_valid = 1;
          mem_rsp_data = fix_en ? fix_data : $urandom;
          pend = 0;
        end else cnt--;
      end else if (kick_req != kick_done) begin
        mem_rsp_valid = 1;
        mem_rsp_data = $urandom;
        kick_done = kick_req;
      end else if (spur && $urandom_range(0, 15) == 0) begin
        mem_rsp_valid = 1;
        mem_rsp_data = $urandom;
      end
      mem_req_ready = $urandom_range(0, 99) < rdy_pct;
    end
  end

  // reference model (transaction level) feeding the scoreboard, then the monitor that drains it
  logic [68:0] mem_q[$];
  logic [65:0] rsp_q[$];
  bit busy = 0, acc_ph = 0, drop = 0, own_ifu = 0, e_l, e_i, ifu_ok;
  int starve = 0, n_ifu_rsp = 0, n_lsu_rsp = 0;
  always begin
    @(negedge clk);
    if (!rst_n) begin
      busy = 0; acc_ph = 0; drop = 0; starve = 0;
      mem_q.delete(); rsp_q.delete();
    end else if (!busy) begin
      ifu_ok = ifu_req_valid && !ifu_flush;
      e_l = lsu_req_valid && !(ifu_ok && starve == LIM);
      e_i = ifu_ok && !e_l;
      chk("grant", {ifu_req_ready_o, lsu_req_ready_o}, {e_i, e_l});
      chk("idle_mem_valid", mem_req_valid_o, 0);
      if (!lsu_req_valid && !ifu_req_valid) chk("idle_fields", {mem_addr_o, mem_wdata_o, mem_wmask_o, mem_wen_o}, 0);
      if (e_l) begin
        mem_q.push_back({lsu_req_addr, lsu_req_wdata, lsu_req_wmask, lsu_req_wen});
        own_ifu = 0;
        if (ifu_ok && starve < LIM) starve++;
      end
      if (e_i) begin
        mem_q.push_back({ifu_req_addr, 32'h0, 4'h0, 1'b0});
        own_ifu = 1;
        starve = 0;
      end
      busy = e_l || e_i; acc_ph = 0; drop = 0;
    end else begin
      chk("busy_ready", {ifu_req_ready_o, lsu_req_ready_o}, 0);
      chk("busy_mem_valid", mem_req_valid_o, !acc_ph);
      if (!acc_ph) acc_ph = mem_req_ready;
      else if (mem_rsp_valid) begin
        if (!own_ifu) rsp_q.push_back({2'b01, 32'h0, mem_rsp_data});
        else if (!drop && !ifu_flush) rsp_q.push_back({2'b10, mem_rsp_data, 32'h0});
        busy = 0;
      end
      if (own_ifu && ifu_flush) drop = 1;
    end
    #1;
    if (!rst_n) begin
      chk("reset_outputs", {ifu_req_ready_o, lsu_req_ready_o, mem_req_valid_o, ifu_rsp_valid_o, lsu_rsp_valid_o,
                            mem_wen_o, mem_wmask_o, mem_addr_o, mem_wdata_o}, 0);
    end else begin
      if (mem_req_valid_o) begin
        if (mem_q.size() == 0) chk("mem_req_extra", mem_req_valid_o, 0);
        else begin
          chk("mem_req_fields", {mem_addr_o, mem_wdata_o, mem_wmask_o, mem_wen_o}, mem_q[0]);
          if (mem_req_ready) void'(mem_q.pop_front());
        end
      end
      if (ifu_rsp_valid_o) n_ifu_rsp++;
      if (lsu_rsp_valid_o) n_lsu_rsp++;
      if (ifu_rsp_valid_o || lsu_rsp_valid_o) begin
        if (rsp_q.size() == 0) chk("rsp_extra", {ifu_rsp_valid_o, lsu_rsp_valid_o}, 0);
        else chk("rsp", {ifu_rsp_valid_o, lsu_rsp_valid_o, ifu_rsp_data_o, lsu_rsp_data_o}, rsp_q.pop_front());
      end
      if (rsp_q.size() != 0) begin
        chk("rsp_missing", rsp_q.size(), 0);
        rsp_q.delete();
      end
    end
  end

  // main sequence: directed scenarios, then randomized traffic, then drain
  logic [9:0] order;
  int ng, n0;
  initial begin
    d_lsu_v = 1; d_lsu_addr = 32'h1000;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    @(negedge clk); #2 chk("first_grant_after_reset", {ifu_req_ready_o, lsu_req_ready_o}, 2'b01);
    @(posedge clk); d_lsu_v = 0;
    repeat (4) @(posedge clk);
    fix_en = 1; fix_data = 32'hDEAD_BEEF;
    @(posedge clk); d_lsu_v = 1; d_lsu_addr = 32'h8000_0010; d_lsu_wen = 0;
    @(negedge clk); #2 chk("load_c0_ready", lsu_req_ready_o, 1);
    @(posedge clk); d_lsu_v = 1; d_lsu_addr = 32'h8000_0014;
    @(negedge clk); #2 chk("load_c1_req", {mem_req_valid_o, mem_addr_o, mem_wen_o}, {1'b1, 32'h8000_0010, 1'b0});
    @(negedge clk); #2 chk("load_c2_rsp", {ifu_rsp_valid_o, lsu_rsp_valid_o, lsu_rsp_data_o}, {2'b01, 32'hDEAD_BEEF});
    @(negedge clk); #2 chk("load_c3_regrant", lsu_req_ready_o, 1);
    @(posedge clk); d_lsu_v = 0;
    repeat (4) @(posedge clk);
    fix_en = 0;
    order = 0; ng = 0;
    @(posedge clk); d_ifu_v = 1; d_ifu_addr = 32'h40; d_lsu_v = 1; d_lsu_wen = 1; d_lsu_wmask = 4'b0011; d_lsu_wdata = 32'h1234_5678;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk); #2;
      if (c == 0) chk("contest_first_lsu", {ifu_req_ready_o, lsu_req_ready_o}, 2'b01);
      if (c == 1) chk("store_wmask_wen", {mem_wmask_o, mem_wen_o}, {4'b0011, 1'b1});
      if ((ifu_req_ready_o || lsu_req_ready_o) && ng < 10) begin
        order[ng] = ifu_req_ready_o;
        ng++;
      end
    end
    chk("grant_order", {ng[7:0], order}, {8'd10, 10'b1000010000});
    @(posedge clk); d_ifu_v = 0; d_lsu_v = 0;
    repeat (6) @(posedge clk);
    rdy_pct = 0; n0 = n_lsu_rsp;
    @(posedge clk); d_lsu_v = 1; d_lsu_addr = 32'h2000; d_lsu_wdata = 32'hCAFE_0001; d_lsu_wmask = 4'hF; d_lsu_wen = 1;
    @(negedge clk); #2 chk("stall_grant", lsu_req_ready_o, 1);
    @(posedge clk); d_lsu_v = 1; d_ifu_v = 1; d_lsu_addr = 32'h2004;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #2;
      chk("stall_req", {mem_req_valid_o, mem_addr_o, mem_wdata_o}, {1'b1, 32'h2000, 32'hCAFE_0001});
      chk("stall_ready", {ifu_req_ready_o, lsu_req_ready_o}, 0);
    end
    @(posedge clk); rdy_pct = 100; d_lsu_v = 0; d_ifu_v = 0;
    repeat (2) @(negedge clk);
    #2 chk("stall_resume", n_lsu_rsp - n0, 1);
    repeat (4) @(posedge clk);
    dly_min = 3; dly_max = 3; n0 = n_ifu_rsp;
    @(posedge clk); d_ifu_v = 1; d_ifu_addr = 32'h100;
    @(negedge clk); #2 chk("fetch_grant", ifu_req_ready_o, 1);
    @(posedge clk); d_ifu_v = 0;
    @(posedge clk);
    @(posedge clk); d_flush = 1;
    @(posedge clk); d_flush = 0;
    repeat (6) @(posedge clk);
    d_lsu_v = 1; d_lsu_addr = 32'h300; d_lsu_wen = 0;
    @(negedge clk); #2 chk("flush_no_rsp", n_ifu_rsp - n0, 0);
    chk("flush_back_idle", lsu_req_ready_o, 1);
    @(posedge clk); d_lsu_v = 0;
    repeat (8) @(posedge clk);
    dly_min = 5; dly_max = 5;
    @(posedge clk); d_lsu_v = 1; d_lsu_addr = 32'h400;
    @(posedge clk); d_lsu_v = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 0; d_lsu_v = 1; d_ifu_v = 1;
    @(negedge clk); #2 chk("reset_mid_outputs", {ifu_req_ready_o, lsu_req_ready_o, mem_req_valid_o, ifu_rsp_valid_o, lsu_rsp_valid_o}, 0);
    @(posedge clk); d_lsu_v = 0; d_ifu_v = 0;
    @(posedge clk); #3 rst_n = 1; n0 = n_ifu_rsp + n_lsu_rsp; kick_req++;
    repeat (8) @(negedge clk);
    #2 chk("reset_no_rsp", n_ifu_rsp + n_lsu_rsp - n0, 0);
    dly_min = 0; dly_max = 3; rdy_pct = 70;
    @(posedge clk); auto_drv = 1; spur = 1;
    repeat (1500) @(posedge clk);
    #3 rst_n = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    repeat (1500) @(posedge clk);
    auto_drv = 0; spur = 0;
    repeat (30) @(posedge clk);
    @(negedge clk); #2 chk("drain_mem_q", mem_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end
endmodule

// File: doc/core_biu_arbiter.md
CORE_BIU_ARBITER -- requirements
Module: core_biu_arbiter

Interface
REQ-001 Parameter XLEN, 32, data and address width.
REQ-002 Parameter WMASK_W, 4, byte write-mask width.
REQ-003 Parameter STARVE_LIMIT, 4, consecutive contested LSU grants before the IFU is forced; legal range 1..15.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 ifu_req_valid / ifu_req_ready  in/out  1  IFU fetch request handshake; IFU requests are read-only.
REQ-007 ifu_req_addr  in  XLEN  fetch address.
REQ-008 ifu_flush  in  1  pipeline flush; the IFU discards any in-flight fetch.
REQ-009 ifu_rsp_valid / ifu_rsp_data  out  1 / XLEN  fetch response, one-cycle pulse, no backpressure.
REQ-010 lsu_req_valid / lsu_req_ready  in/out  1  LSU request handshake.
REQ-011 lsu_req_addr, lsu_req_wdata, lsu_req_wmask, lsu_req_wen  in  XLEN, XLEN, WMASK_W, 1  LSU address, store data, byte mask and write flag.
REQ-012 lsu_rsp_valid / lsu_rsp_data  out  1 / XLEN  LSU response pulse; data is meaningful only for loads.
REQ-013 mem_req_valid / mem_req_ready  out/in  1  memory-side request handshake.
REQ-014 mem_addr, mem_wdata, mem_wmask, mem_wen  out  XLEN, XLEN, WMASK_W, 1  registered request fields.
REQ-015 mem_rsp_valid / mem_rsp_data  in  1 / XLEN  memory response; exactly one response per accepted request, including writes.

Function
REQ-016 The block shall hold one transaction at a time, using FSM states IDLE, REQ and WAIT.
REQ-017 In IDLE, the block shall select a winner combinationally and drive ready high only to the winner; the ready of the other requester shall be 0.
REQ-018 Arbitration: the LSU shall win over the IFU, except when starve_cnt equals STARVE_LIMIT; in that case the IFU shall win.
REQ-019 In IDLE, the IFU shall not be granted while ifu_flush is 1.
REQ-020 On the grant handshake, the block shall latch addr, wdata, wmask, wen and owner (IFU: wen=0, wmask=0), then go IDLE->REQ.
REQ-021 In REQ, mem_req_valid shall be 1 and the request fields shall be stable; on mem_req_ready the FSM shall go REQ->WAIT.
REQ-022 In WAIT, on mem_rsp_valid the block shall route mem_rsp_data combinationally to the owner rsp_data and pulse the owner rsp_valid for that same cycle, then go WAIT->IDLE.
REQ-023 In REQ and WAIT, both req_ready outputs shall be 0, and mem_rsp_valid seen in IDLE or REQ shall be ignored.
REQ-024 Minimum latency shall be 3 cycles (grant in c0, mem_req_valid in c1 with ready, response in c2, new grant in c3), with zero wait states inserted by the arbiter.
REQ-025 starve_cnt is 4 bits and shall increment on an LSU grant while ifu_req_valid=1 and ifu_flush=0, saturating at STARVE_LIMIT.
REQ-026 starve_cnt shall clear on any IFU grant, and shall hold otherwise.
REQ-027 The drop flag shall be set when ifu_flush=1 while the owner is the IFU and the state is REQ or WAIT.
REQ-028 While the drop flag is set, the block shall still complete the IFU transaction but suppress ifu_rsp_valid; the flag shall clear on return to IDLE.
REQ-029 If ifu_flush and mem_rsp_valid occur in the same WAIT cycle for an IFU transaction, the response shall be suppressed.
REQ-030 ifu_flush shall never affect an LSU transaction.
REQ-031 When no requester is valid, the block shall remain in IDLE with all memory outputs at 0.

Reset
REQ-032 On rst_n=0, the block shall immediately set state=IDLE, starve_cnt=0, drop=0 and owner=LSU, and zero all latched request fields.
REQ-033 During reset, all outputs shall be 0: mem_req_valid, ifu/lsu_rsp_valid, both req_ready, and all mem fields.
REQ-034 Reset asserted mid-transaction shall abandon it, and no rsp_valid shall be produced for it after release.
REQ-035 After release, the first grant shall be possible in the first cycle with rst_n=1.

Verification
REQ-036 LSU load only: addr 0x8000_0010, mem_req_ready held 1, response 0xDEAD_BEEF one cycle after acceptance -> lsu_rsp_valid pulses in c2 with 0xDEAD_BEEF; ifu_rsp_valid stays 0.
REQ-037 Simultaneous requests in IDLE, starve_cnt=0 -> LSU granted; a store with wmask 0b0011 appears on mem_wmask with mem_wen=1; starve_cnt becomes 1.
REQ-038 Both requesters continuously valid, STARVE_LIMIT=4 -> grant order LSU,LSU,LSU,LSU,IFU,LSU...; starve_cnt returns to 0 after the IFU grant.
REQ-039 IFU fetch accepted, then ifu_flush pulsed during WAIT with a 3-cycle memory delay -> no ifu_rsp_valid; FSM returns to IDLE after mem_rsp_valid.
REQ-040 mem_req_ready held 0 for 5 cycles -> mem_req_valid and fields stay stable; both req_ready stay 0; progress resumes on ready.
REQ-041 rst_n asserted in WAIT, then mem_rsp_valid pulsed after release -> no rsp_valid; state IDLE; all outputs 0 during reset.
